// File: rtl/iic_pkg.sv
// iic_pkg: shared IIC slave/master state enumeration and default ADXL345 target address
package iic_pkg;
  typedef enum logic [3:0] {
    IDLE, DEVADDR, DEVACK, REGADDR, REGACK, WRDATA, WRACK, RDDATA, RDACK, IGNORE
  } iic_state_e;
  localparam logic [6:0] ADXL345_ADDR = 7'h53;
endpackage

// File: rtl/iic_in_filter.sv
// iic_in_filter: 2-flop sync + FILT_LEN glitch filter on scl_i/sda_i, emits sda_f and one-clk scl_rise/scl_fall/start/stop pulses
module iic_in_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [1:0]         raw;
  logic [1:0][1:0]    sync_q, sync_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         filt_q, filt_d;
  logic [3:0]         ev_q, ev_d;
  assign raw = {sda_i, scl_i};
  always_comb begin
    sync_d = sync_q;
    cnt_d  = cnt_q;
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][0], raw[i]};
      cnt_d[i]  = (sync_q[i][1] == filt_q[i] || cnt_q[i] == CW'(FILT_LEN - 1)) ? '0 : cnt_q[i] + 1'b1;
      filt_d[i] = (sync_q[i][1] != filt_q[i] && cnt_q[i] == CW'(FILT_LEN - 1)) ? sync_q[i][1] : filt_q[i];
    end
    ev_d = {filt_d[1] & ~filt_q[1] & filt_q[0] & filt_d[0],
            ~filt_d[1] & filt_q[1] & filt_q[0] & filt_d[0],
            ~filt_d[0] & filt_q[0],
            filt_d[0] & ~filt_q[0]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= '1;
      ev_q   <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      ev_q   <= ev_d;
    end
  end
  assign sda_f    = filt_q[1];
  assign scl_rise = ev_q[0];
  assign scl_fall = ev_q[1];
  assign start    = ev_q[2];
  assign stop     = ev_q[3];
endmodule

// File: rtl/iic_slave.sv
// iic_slave: IIC register-access target; scl/sda bus in, reg_wr/reg_addr/reg_wrdb/reg_rd out, reg_rddb in, busy out
module iic_slave
  import iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = ADXL345_ADDR,
  parameter int         FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wrdb,
  output logic       reg_rd,
  input  logic [7:0] reg_rddb,
  output logic       busy
);
  iic_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d, addr_q, addr_d, wrdb_q, wrdb_d;
  logic       oe_q, oe_d, wr_q, wr_d, rd_q, rd_d, busy_q, busy_d, rw_q, rw_d;
  logic       sda_f, scl_rise, scl_fall, start, stop, hit;
  iic_in_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda), .sda_f(sda_f),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
  );
  assign hit = sr_q[7:1] == DEV_ADDR;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    oe_d    = oe_q;
    addr_d  = addr_q;
    wrdb_d  = wrdb_q;
    rw_d    = rw_q;
    busy_d  = busy_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    if (rd_q) begin
      sr_d = reg_rddb;
      oe_d = ~reg_rddb[7];
    end
    case (state_q)
      DEVADDR, REGADDR, WRDATA: begin
        if (scl_rise && cnt_q != 4'd8) begin
          sr_d  = {sr_q[6:0], sda_f};
          cnt_d = cnt_q + 4'd1;
        end
        if (scl_fall && cnt_q == 4'd8) begin
          cnt_d = '0;
          oe_d  = 1'b1;
          if (state_q == DEVADDR) begin
            state_d = hit ? DEVACK : IGNORE;
            oe_d    = hit;
            busy_d  = busy_q | hit;
            rw_d    = sr_q[0];
          end else if (state_q == REGADDR) begin
            state_d = REGACK;
            addr_d  = sr_q;
          end else begin
            state_d = WRACK;
            wr_d    = 1'b1;
            wrdb_d  = sr_q;
          end
        end
      end
      DEVACK, REGACK, WRACK: begin
        if (scl_fall) begin
          oe_d    = 1'b0;
          cnt_d   = '0;
          state_d = state_q != DEVACK ? WRDATA : rw_q ? RDDATA : REGADDR;
          rd_d    = state_q == DEVACK && rw_q;
          addr_d  = addr_q + {7'd0, state_q == WRACK};
        end
      end
      RDDATA: begin
        if (scl_rise) cnt_d = cnt_q + 4'd1;
        if (scl_fall) begin
          state_d = cnt_q == 4'd8 ? RDACK : RDDATA;
          oe_d    = cnt_q != 4'd8 && ~sr_q[6];
          sr_d    = {sr_q[6:0], 1'b0};
        end
      end
      RDACK: begin
        if (scl_rise && sda_f) state_d = IGNORE;
        if (scl_fall) begin
          state_d = RDDATA;
          cnt_d   = '0;
          addr_d  = addr_q + 8'd1;
          rd_d    = 1'b1;
        end
      end
      default: ;
    endcase
    if (start) begin
      state_d = DEVADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      wrdb_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
      wrdb_q  <= wrdb_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
    end
  end
  assign sda      = oe_q ? 1'b0 : 1'bz;
  assign reg_wr   = wr_q;
  assign reg_rd   = rd_q;
  assign reg_addr = addr_q;
  assign reg_wrdb = wrdb_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_iic_slave.sv
// tb_iic_slave: bus-level master driving iic_slave against a register-file model with queued strobe expectations
module tb_iic_slave;
  localparam logic [6:0] DEV = 7'h53;
  localparam int Q = 16;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda;
  logic       reg_wr, reg_rd, busy;
  logic [7:0] reg_addr, reg_wrdb, reg_rddb;
  logic [7:0] mem [256];
  int         checks = 0;
  int         errors = 0;
  int         both = 0;
  logic [15:0] wq[$], ewq[$];
  logic [7:0]  rq[$], erq[$];
  always #5 clk = ~clk;
  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);
  assign reg_rddb = mem[reg_addr];
  iic_slave dut (
    .clk(clk), .rst_n(rst_n), .scl(m_scl), .sda(sda), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wrdb(reg_wrdb), .reg_rd(reg_rd), .reg_rddb(reg_rddb), .busy(busy)
  );
  always @(negedge clk) begin
    if (reg_wr) wq.push_back({reg_addr, reg_wrdb});
    if (reg_rd) rq.push_back(reg_addr);
    if (reg_wr && reg_rd) both++;
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk_reset();
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_reg_rd", reg_rd, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wrdb", reg_wrdb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sda", sda, 1);
  endtask
  task automatic bus_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask
  task automatic bus_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask
  task automatic bit_x(input logic b, input logic glitch, output logic r);
    m_sda = b;
    tick(Q / 2);
    if (glitch) begin
      m_scl = 1'b1; tick(2);
      m_scl = 1'b0;
    end
    tick(Q / 2);
    m_scl = 1'b1; tick(Q);
    r = sda; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask
  task automatic wr_byte(input logic [7:0] d, input logic glitch, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(d[i], glitch && i == 4, r);
    bit_x(1'b1, 1'b0, ack);
  endtask
  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, 1'b0, r);
      d[i] = r;
    end
    bit_x(nack, 1'b0, r);
  endtask
  task automatic wr_txn(input logic [7:0] ptr, input int n, input logic [7:0] first, input logic glitch);
    logic a;
    logic [7:0] d;
    bus_start();
    wr_byte({DEV, 1'b0}, 1'b0, a); chk("wr_dev_ack", a, 0);
    wr_byte(ptr, 1'b0, a); chk("wr_reg_ack", a, 0);
    for (int i = 0; i < n; i++) begin
      d = i == 0 ? first : 8'($urandom);
      ewq.push_back({ptr + 8'(i), d});
      wr_byte(d, glitch && i == 0, a);
      chk("wr_data_ack", a, 0);
    end
    chk("wr_busy", busy, 1);
    bus_stop();
    chk("wr_busy_after_stop", busy, 0);
  endtask
  task automatic rd_txn(input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] d;
    bus_start();
    wr_byte({DEV, 1'b0}, 1'b0, a); chk("rd_dev_ack", a, 0);
    wr_byte(ptr, 1'b0, a); chk("rd_reg_ack", a, 0);
    bus_start();
    wr_byte({DEV, 1'b1}, 1'b0, a); chk("rd_devr_ack", a, 0);
    for (int i = 0; i < n; i++) begin
      erq.push_back(ptr + 8'(i));
      rd_byte(i == n - 1, d);
      chk("rd_data", d, mem[ptr + 8'(i)]);
    end
    bus_stop();
    chk("rd_busy_after_stop", busy, 0);
  endtask
  task automatic cmp_q();
    chk("wr_count", 16'(wq.size()), 16'(ewq.size()));
    for (int i = 0; i < ewq.size() && i < wq.size(); i++) chk("wr_event", wq[i], ewq[i]);
    chk("rd_count", 16'(rq.size()), 16'(erq.size()));
    for (int i = 0; i < erq.size() && i < rq.size(); i++) chk("rd_event", rq[i], erq[i]);
    wq.delete(); ewq.delete(); rq.delete(); erq.delete();
  endtask
  initial begin
    logic a;
    logic [7:0] ptr;
    foreach (mem[i]) mem[i] = 8'($urandom);
    tick(5);
    chk_reset();
    rst_n = 1'b1;
    tick(Q);
    wr_txn(8'h2D, 1, 8'h08, 1'b0);
    cmp_q();
    rd_txn(8'h32, 6);
    cmp_q();
    bus_start();
    wr_byte(8'hA8, 1'b0, a); chk("nomatch_ack", a, 1);
    chk("nomatch_busy", busy, 0);
    wr_byte(8'h55, 1'b0, a); chk("nomatch_data_ack", a, 1);
    bus_stop();
    cmp_q();
    wr_txn(8'hFF, 2, 8'($urandom), 1'b1);
    cmp_q();
    chk("wrap_ptr", reg_addr, 8'h01);
    bus_start();
    wr_byte({DEV, 1'b0}, 1'b0, a); chk("abort_dev_ack", a, 0);
    wr_byte(8'h10, 1'b0, a); chk("abort_reg_ack", a, 0);
    for (int i = 0; i < 4; i++) bit_x(i[0], 1'b0, a);
    bus_stop();
    cmp_q();
    chk("abort_busy", busy, 0);
    chk("abort_ptr", reg_addr, 8'h10);
    bus_start();
    wr_byte({DEV, 1'b0}, 1'b0, a);
    wr_byte(8'h10, 1'b0, a);
    for (int i = 0; i < 4; i++) bit_x(1'b1, 1'b0, a);
    rst_n = 1'b0;
    tick(3);
    chk_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) bit_x(i[0], 1'b0, a);
    bit_x(1'b1, 1'b0, a); chk("post_reset_ack", a, 1);
    chk("post_reset_busy", busy, 0);
    bus_stop();
    cmp_q();
    wr_txn(8'h20, 1, 8'($urandom), 1'b0);
    cmp_q();
    for (int k = 0; k < 3; k++) begin
      ptr = 8'($urandom);
      wr_txn(ptr, int'($urandom_range(1, 3)), 8'($urandom), 1'b0);
      cmp_q();
      ptr = 8'($urandom);
      rd_txn(ptr, int'($urandom_range(1, 4)));
      cmp_q();
    end
    chk("wr_rd_overlap", 16'(both), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
